// File: rtl/uart_rx_deframer.sv
// UART receive deframer: oversamples rx_bit on the shared baud strobe and
// recovers 8N1 frames, pushing good bytes into the RX FIFO.
module uart_rx_deframer #(
    parameter int DATA_BITS = 8,
    parameter int OS_RATE   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 uart_tick,
    input  logic                 rx_bit,
    input  logic                 rx_fifo_full,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_push,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 rx_busy
);

    localparam int TW = $clog2(OS_RATE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] HALF_LAST = TW'(OS_RATE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OS_RATE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 sync_0;
    logic                 rx_s;
    logic                 armed;
    logic [DATA_BITS:0]   shift_next;

    // New bit enters at the MSB so the first (LSB) wire bit ends at bit 0.
    assign shift_next = {rx_s, shift};

    // NOTE: every register in this block uses <= so all of them update from
    // the same pre-edge values; mixing in = here would create ordering bugs.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_0    <= 1'b1;
            rx_s      <= 1'b1;
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            armed     <= 1'b0;
            rx_data   <= '0;
            rx_push   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            rx_busy   <= 1'b0;
        end else begin
            sync_0    <= rx_bit;
            rx_s      <= sync_0;
            rx_push   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            if (uart_tick) begin
                if (rx_s) armed <= 1'b1;

                case (state)
                    IDLE: begin
                        if (!rx_s && armed) begin
                            state    <= START;
                            tick_cnt <= '0;
                            armed    <= 1'b0;
                            rx_busy  <= 1'b1;
                        end
                    end
                    START: begin
                        if (tick_cnt == HALF_LAST) begin
                            if (rx_s) begin
                                state   <= IDLE;
                                rx_busy <= 1'b0;
                            end else begin
                                state    <= DATA;
                                tick_cnt <= '0;
                                bit_cnt  <= '0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (tick_cnt == FULL_LAST) begin
                            shift    <= shift_next[DATA_BITS:1];
                            tick_cnt <= '0;
                            bit_cnt  <= bit_cnt + 1'b1;
                            if (bit_cnt == BIT_LAST) state <= STOP;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    STOP: begin
                        if (tick_cnt == FULL_LAST) begin
                            state    <= IDLE;
                            rx_busy  <= 1'b0;
                            tick_cnt <= '0;
                            if (!rx_s) begin
                                // A low stop bit may be a break; wait for the line to go high again.
                                frame_err <= 1'b1;
                                armed     <= 1'b0;
                            end else if (rx_fifo_full) begin
                                overrun <= 1'b1;
                            end else begin
                                rx_push <= 1'b1;
                                rx_data <= shift;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
